fifo_wr_scheduler: RTL
======================

# fifo_wr_scheduler

Write-side scheduler for `asyn_fifo`. It shares one FIFO write port between NREQ requesters in the `clk_a` domain. It grants one requester at a time for a packet burst, using round-robin priority. It gates every accepted word on the FIFO's `almost_full`/`full` flags, so the FIFO never overflows, and it drives the FIFO `write`/`write_data` pins from registers.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `DBITWIDTH`, 32: word width; must equal the FIFO's `DBITWIDTH`.
- `MAX_BURST`, 8: maximum words per grant (1..255).

Ports:
- `clk`  in  1: single clock; the same clock as the FIFO's `clk_a`.
- `rst`  in  1: reset, asynchronous, active-high.
- `clr`  in  1: synchronous clear; tie to the FIFO's `clr_a`.
- `req`  in  NREQ: requester i has a word valid.
- `req_data`  in  NREQ*DBITWIDTH: word of requester i, at bits [i*DBITWIDTH +: DBITWIDTH].
- `req_last`  in  NREQ: the current word is the last word of the packet.
- `ack`  out  NREQ: combinational, one-hot; the word of requester i is accepted this cycle.
- `fifo_almost_full`  in  1: from the FIFO.
- `fifo_full`  in  1: from the FIFO.
- `fifo_write`  out  1: registered; drives the FIFO `write` pin.
- `fifo_write_data`  out  DBITWIDTH: registered; drives the FIFO `write_data` pin.
- `grant_id`  out  clog2(NREQ): currently or last granted requester.
- `busy`  out  1: high while in state XFER.

## Operation
- States:
  - IDLE: no grant.
  - XFER: grant held by `grant_id`.
- Round-robin pointer `last`:
  - The winner in IDLE is the first i with `req[i]=1`, searching upward from `last+1` modulo NREQ.
  - The pointer updates when a grant is issued.
- IDLE → XFER: occurs when any `req` bit is set.
  - The winner is registered into `grant_id`.
  - No word is accepted in the IDLE cycle.
- Accept condition, evaluated in XFER: `accept = req[grant_id] & ~fifo_almost_full & ~fifo_full`.
  - `ack[grant_id] = accept`.
  - On accept, the next cycle has `fifo_write=1` and `fifo_write_data = req_data[grant_id]`.
  - Otherwise `fifo_write=0` and the data register holds its value.
- Burst counter `bcnt` (8 bits):
  - Cleared on entry to XFER.
  - Increments on each accept.
- XFER → IDLE occurs on an accept that meets either of these:
  - `req_last[grant_id]=1`;
  - `bcnt == MAX_BURST-1`. A packet longer than MAX_BURST is split; the requester re-arbitrates for the remainder.
- Stall rules in XFER:
  - If `req[grant_id]` drops, the grant is held with no timeout. This preserves packet integrity.
  - While the flags are asserted, the grant is held and `ack=0`.
- `clr=1`: on the next edge, state goes to IDLE, `bcnt=0`, `last=NREQ-1`, `fifo_write=0`, and `grant_id=0`. `clr` has priority over all other events.
- FIFO constraint: the FIFO must be instantiated with `AF_THRESHOLD >= 2`. This covers the one-cycle register lag plus the one-cycle counter-update lag.

## Timing
- Reset values:
  - state = IDLE, `last = NREQ-1` (requester 0 has first priority).
  - `fifo_write=0`, `fifo_write_data=0`, `grant_id=0`, `busy=0`, `bcnt=0`.
  - `ack=0`, since the state is IDLE.
- Latency:
  - `req` rising edge to first possible `ack`: 1 cycle (the IDLE cycle).
  - `ack` to `fifo_write`: 1 cycle.
- Throughput:
  - One word per cycle within a burst.
  - One IDLE bubble cycle between bursts.
- Flag timing: a flag rising in cycle t blocks the accept in cycle t itself, because the flags feed the accept logic combinationally.
- Simultaneous events:
  - `req_last` together with `bcnt==MAX_BURST-1` gives a single release.
  - Release and a new request give IDLE for one cycle, then the next grant.
- Asynchronous `rst` mid-burst: all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Package `fifo_sched_pkg` contains:
  - the state enum (IDLE=1'b0, XFER=1'b1);
  - the constant `BCNT_W=8`;
  - a `clog2` function used for the `grant_id` width.
- Sub-module `rr_pick`: a combinational round-robin selector with inputs `req` and `last`, and outputs `winner` and `any`.
- The scheduler contains the state register, `bcnt`, and the output registers.

## Test plan
- Single packet: requester 2 sends a 3-word packet (A,B,C, with `req_last` on C). Required response:
  - `busy` rises 1 cycle after `req`;
  - three `ack[2]` pulses;
  - `fifo_write` sequence A,B,C, each 1 cycle after its ack;
  - then IDLE.
- Fairness: all 4 requesters hold single-word packets continuously. Required grant order is 0,1,2,3,0,1, with one word every 2 cycles.
- Burst cap with MAX_BURST=8: requester 0 sends a 10-word packet while requester 1 waits. Required response:
  - 8 words from requester 0;
  - then requester 1's packet;
  - then the remaining 2 words from requester 0.
- Backpressure: `fifo_almost_full=1` for 5 cycles during word 2 of a burst. Required response:
  - `ack=0` and `fifo_write=0` for those cycles;
  - the grant is kept;
  - the data sequence is unchanged.
- Clear: `clr` is pulsed mid-burst (word 3 of 6). Required response:
  - next cycle: IDLE, `fifo_write=0`, `grant_id=0`;
  - the next grant goes to the lowest active requester.
- Async reset: `rst` is asserted between clock edges during XFER. All outputs must take their reset values before the next edge.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO write-side scheduler.
//   state_e : scheduler state (IDLE = no grant, XFER = grant held)
//   BCNT_W  : width of the per-grant burst counter
//   clog2   : index width helper (never returns less than 1)
package fifo_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam int BCNT_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector
//   last   : most recently granted index; search starts at last+1 (mod NREQ)
//   winner : first requesting index found in that order
//   any    : at least one request is pending
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   winner,
  output logic            any
);

  logic          found;
  logic [GW-1:0] idx;

  assign any = |req;

  // Walk the ring once starting just after the previous winner; the first
  // hit wins, so the previous winner is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_scheduler.sv
// fifo_wr_scheduler: shares one asyn_fifo write port among NREQ requesters
// in the FIFO's write clock domain. Grants one requester per packet burst
// (round-robin), gates each word on almost_full/full, and drives the FIFO
// write pins from registers.
//   clk, rst             : write clock, async active-high reset
//   clr                  : sync clear (tie to the FIFO's clr_a)
//   req/req_data/req_last: per-requester word valid, data, end-of-packet
//   ack                  : one-hot, combinational word-accepted strobe
//   fifo_almost_full/full: FIFO flags, gate acceptance combinationally
//   fifo_write/_data     : registered FIFO write pins
//   grant_id, busy       : current/last grant, high while a grant is held
// The FIFO needs AF_THRESHOLD >= 2: one cycle of write-register lag plus one
// cycle before the FIFO's own fill count reflects the write.
module fifo_wr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DBITWIDTH = 32,
  parameter  int MAX_BURST = 8,
  localparam int GW        = clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DBITWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           ack,
  input  logic                      fifo_almost_full,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DBITWIDTH-1:0]      fifo_write_data,
  output logic [GW-1:0]             grant_id,
  output logic                      busy
);

  state_e               state, next_state;
  logic [BCNT_W-1:0]    bcnt;
  logic [GW-1:0]        last, winner;
  logic                 any, accept, rel;
  logic [DBITWIDTH-1:0] gdata;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  assign gdata  = req_data[int'(grant_id)*DBITWIDTH +: DBITWIDTH];
  assign accept = (state == XFER) & req[grant_id] & ~fifo_almost_full & ~fifo_full;
  // End of packet and burst cap landing on the same word is a single release.
  assign rel    = accept & (req_last[grant_id] | (bcnt == BCNT_W'(MAX_BURST - 1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic. A dropped req in XFER just holds the grant: leaving
  // mid-packet would interleave packets in the FIFO.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any) next_state = XFER;
      XFER:    if (rel) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    ack           = '0;
    ack[grant_id] = accept;
    busy          = (state == XFER);
  end

  // Grant, burst counter and FIFO write registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last            <= GW'(NREQ - 1);
      grant_id        <= '0;
      bcnt            <= '0;
      fifo_write      <= 1'b0;
      fifo_write_data <= '0;
    end else if (clr) begin
      last       <= GW'(NREQ - 1);
      grant_id   <= '0;
      bcnt       <= '0;
      fifo_write <= 1'b0;
    end else begin
      fifo_write <= accept;
      if (state == IDLE && any) begin
        grant_id <= winner;
        last     <= winner;
        bcnt     <= '0;
      end
      if (accept) begin
        fifo_write_data <= gdata;
        bcnt            <= bcnt + 1'b1;
      end
    end
  end

endmodule
